// File: rtl/pointcloud_stream_mux_if.sv
// ---------------------------------------------------------------------------
// pointcloud_stream_mux_if
//
// Signal bundle for the point-cloud stream multiplexer.
//
// Parameters
//   WIDTH  data width of one channel
//   N_CH   number of input channels
//   SEL_W  width of the channel select / channel index
//
// Signals
//   in_data   N_CH*WIDTH  packed channel data, channel c at [c*WIDTH +: WIDTH]
//   in_valid  N_CH        per-channel beat valid
//   in_last   N_CH        per-channel end-of-packet, qualified by in_valid
//   in_ready  N_CH        per-channel accept (one-hot or zero)
//   sel       SEL_W       external channel select (used when rr_en = 0)
//   rr_en     1           1 = round-robin arbitration, 0 = external select
//   out_data  WIDTH       registered output data
//   out_valid 1           output beat valid
//   out_last  1           output end-of-packet
//   out_ch    SEL_W       source channel of the current output beat
//   out_ready 1           downstream accept
//
// Modports
//   slave   the mux side facing the upstream channels (plus mode controls)
//   master  the mux side driving the merged downstream stream
// ---------------------------------------------------------------------------
interface pointcloud_stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 3,
  parameter int SEL_W = 2
);
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic [SEL_W-1:0]      sel;
  logic                  rr_en;

  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_last;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    input  sel,
    input  rr_en,
    output in_ready
  );

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_ch,
    input  out_ready
  );
endinterface

// File: rtl/pointcloud_stream_mux.sv
// ---------------------------------------------------------------------------
// pointcloud_stream_mux
//
// Merges N_CH valid/ready sample streams (depth, colour, alpha matte, ...)
// into one registered downstream stream. The source channel is picked either
// from an external select or by a round-robin arbiter, and once a packet has
// started its channel stays granted until the beat carrying `last` has been
// transferred.
//
// Ports
//   Clk    rising-edge clock
//   Rst_n  asynchronous, active-low reset
//   s_in   upstream side: in_data/in_valid/in_last/in_ready, sel, rr_en
//   m_out  downstream side: out_data/out_valid/out_last/out_ch, out_ready
//
// Behaviour summary
//   - IDLE: the candidate channel is re-evaluated every cycle (sel, or the
//     first valid channel at or after rr_ptr when rr_en = 1).
//   - LOCKED: the grant is pinned to lock_ch; sel/rr_en are ignored and a
//     channel that drops in_valid mid-packet is simply waited for.
//   - The output register is a single stage (no skid buffer): a new beat can
//     be accepted only when the register is empty or being drained.
//   - Every transfer that carries last moves rr_ptr to the channel after the
//     one that just finished, in both arbitration modes.
// ---------------------------------------------------------------------------
module pointcloud_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 3,
  parameter int SEL_W = 2
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  pointcloud_stream_mux_if.slave  s_in,
  pointcloud_stream_mux_if.master m_out
);

  // -------------------------------------------------------------------------
  // FSM encoding
  // -------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]       state;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] rr_ptr;

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [SEL_W-1:0] out_ch_q;

  // -------------------------------------------------------------------------
  // Combinational arbitration
  // -------------------------------------------------------------------------
  logic             cand_vld;
  logic [SEL_W-1:0] cand_ch;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_ch;
  logic             can_accept;
  logic [N_CH-1:0]  in_ready_c;
  logic             xfer;
  logic             xfer_last;
  logic [WIDTH-1:0] xfer_data;
  logic [SEL_W-1:0] rr_next;

  // Channel index rr_ptr + off, wrapped into 0..N_CH-1. Both operands are
  // already below N_CH, so one conditional subtract is enough.
  function automatic int wrap_add(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= N_CH) ? sum - N_CH : sum;
  endfunction

  // IDLE candidate. In round-robin mode the loop walks the offsets from the
  // far end back towards rr_ptr, so the last write wins and that is the
  // closest valid channel at or after rr_ptr.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    cand_vld = 1'b0;
    cand_ch  = '0;
    if (!s_in.rr_en) begin
      if (int'(s_in.sel) < N_CH) begin
        cand_vld = 1'b1;
        cand_ch  = s_in.sel;
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (s_in.in_valid[wrap_add(int'(rr_ptr), i)]) begin
          cand_vld = 1'b1;
          cand_ch  = SEL_W'(wrap_add(int'(rr_ptr), i));
        end
      end
    end
  end

  // A locked packet overrides whatever the select / arbiter would pick.
  always_comb begin
    grant_vld = cand_vld;
    grant_ch  = cand_ch;
    if (state == ST_LOCKED) begin
      grant_vld = 1'b1;
      grant_ch  = lock_ch;
    end
  end

  // The single output stage can take a beat when it is empty or draining.
  // Rst_n gates it so in_ready is all-zero for the whole reset window.
  assign can_accept = Rst_n && (!out_valid_q || m_out.out_ready);

  always_comb begin
    in_ready_c = '0;
    xfer       = 1'b0;
    xfer_last  = 1'b0;
    xfer_data  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant_vld && (grant_ch == SEL_W'(c))) begin
        in_ready_c[c] = can_accept;
        xfer          = can_accept && s_in.in_valid[c];
        xfer_last     = s_in.in_last[c];
        xfer_data     = s_in.in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  assign s_in.in_ready = in_ready_c;

  assign rr_next = (grant_ch == LAST_CH) ? '0 : grant_ch + SEL_W'(1);

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_last_q  <= xfer_last;
      out_data_q  <= xfer_data;
      out_ch_q    <= grant_ch;
    end else if (m_out.out_ready) begin
      // Beat drained with nothing to replace it; payload fields just hold.
      out_valid_q <= 1'b0;
    end
  end

  assign m_out.out_data  = out_data_q;
  assign m_out.out_valid = out_valid_q;
  assign m_out.out_last  = out_last_q;
  assign m_out.out_ch    = out_ch_q;

  // -------------------------------------------------------------------------
  // Packet lock FSM and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      if (xfer_last) begin
        // Packet finished (including single-beat packets): unlock and hand
        // priority to the next channel.
        state  <= ST_IDLE;
        rr_ptr <= rr_next;
      end else begin
        state   <= ST_LOCKED;
        lock_ch <= grant_ch;
      end
    end
  end

endmodule
